// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port (in: clk, rst, req, req_data, fifo_full; out: gnt, fifo_wr_en, fifo_data_in, owner, busy)
module fifo_wr_arbiter #(
  parameter int N = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST = 4,
  localparam int OW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req,
  input  logic [N*DATA_WIDTH-1:0] req_data,
  output logic [N-1:0]            gnt,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [DATA_WIDTH-1:0]   fifo_data_in,
  output logic [OW-1:0]           owner,
  output logic                    busy
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t r_state, w_nstate;
  logic [OW-1:0] r_rr, w_nrr, r_owner, w_nowner, w_pick, w_idx, w_succ;
  logic [7:0] r_cnt, w_ncnt;
  logic [DATA_WIDTH-1:0] w_words [N];
  logic w_acc;
  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_words
      assign w_words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate
  assign busy         = (r_state == BURST);
  assign owner        = r_owner;
  assign w_acc        = busy & req[r_owner] & ~fifo_full;
  assign gnt          = w_acc ? (N'(1) << r_owner) : '0;
  assign fifo_wr_en   = w_acc;
  assign fifo_data_in = busy ? w_words[r_owner] : '0;
  assign w_succ       = (r_owner == OW'(N-1)) ? '0 : r_owner + 1'b1;
  always_comb begin
    w_pick = r_rr;
    w_idx  = r_rr;
    for (int k = N-1; k >= 0; k--) begin
      w_idx = OW'((int'(r_rr) + k) % N);
      w_pick = req[w_idx] ? w_idx : w_pick;
    end
  end
  always_comb begin
    w_nstate = r_state;
    w_nrr    = r_rr;
    w_nowner = r_owner;
    w_ncnt   = r_cnt;
    if (r_state == IDLE) begin
      if (|req && !fifo_full) begin
        w_nstate = BURST;
        w_nowner = w_pick;
        w_ncnt   = '0;
      end
    end else if (!req[r_owner] || (w_acc && r_cnt == 8'(MAX_BURST-1))) begin
      w_nstate = IDLE;
      w_nrr    = w_succ;
    end else if (w_acc) begin
      w_ncnt = r_cnt + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr    <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_rr    <= w_nrr;
      r_owner <= w_nowner;
      r_cnt   <= w_ncnt;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed plus random stimulus checked against a behavioural burst-arbiter model
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, MB = 4;
  logic clk = 1'b0, rst, fifo_full, fifo_wr_en, busy;
  logic [N-1:0] req, gnt;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0] fifo_data_in;
  logic [1:0] owner;
  int total = 0, bad = 0;
  int m_busy, m_owner, m_rr, m_cnt;
  logic [DW-1:0] word [N];
  logic [N-1:0] cur;
  always #5 clk = ~clk;
  fifo_wr_arbiter #(.N(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .owner(owner), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic int first_req(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) if (r[(from + k) % N]) return (from + k) % N;
    return 0;
  endfunction
  task automatic step(input logic [N-1:0] r, input logic f, input logic rs);
    int acc;
    req = r;
    fifo_full = f;
    rst = rs;
    for (int j = 0; j < N; j++) req_data[j*DW +: DW] = word[j];
    @(negedge clk);
    acc = (m_busy != 0 && r[m_owner] && !f) ? 1 : 0;
    chk("gnt", 32'(gnt), acc != 0 ? 32'(1 << m_owner) : 32'd0);
    chk("wr_en", 32'(fifo_wr_en), 32'(acc));
    chk("data", 32'(fifo_data_in), m_busy != 0 ? 32'(word[m_owner]) : 32'd0);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("owner", 32'(owner), 32'(m_owner));
    @(posedge clk);
    if (acc != 0) word[m_owner] = word[m_owner] + 8'd1;
    if (rs) begin
      m_busy = 0; m_owner = 0; m_rr = 0; m_cnt = 0;
    end else if (m_busy == 0) begin
      if (r != '0 && !f) begin
        m_owner = first_req(r, m_rr); m_cnt = 0; m_busy = 1;
      end
    end else if (!r[m_owner]) begin
      m_busy = 0; m_rr = (m_owner + 1) % N;
    end else if (acc != 0) begin
      m_cnt++;
      if (m_cnt == MB) begin
        m_busy = 0; m_rr = (m_owner + 1) % N;
      end
    end
    #1;
  endtask
  initial begin
    for (int j = 0; j < N; j++) word[j] = 8'(j * 16);
    word[2] = 8'hA0;
    rst = 1'b1; req = '0; fifo_full = 1'b0; req_data = '0;
    @(posedge clk); #1;
    m_busy = 0; m_owner = 0; m_rr = 0; m_cnt = 0;
    repeat (2) step(4'b1111, 1'b0, 1'b1);
    repeat (3) step(4'b1111, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    repeat (12) step(4'b0100, 1'b0, 1'b0);
    repeat (26) step(4'b1111, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    repeat (3) step(4'b0010, 1'b0, 1'b0);
    repeat (3) step(4'b0010, 1'b1, 1'b0);
    repeat (2) step(4'b0010, 1'b0, 1'b0);
    repeat (3) step(4'b0110, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    repeat (3) step(4'b0110, 1'b0, 1'b0);
    repeat (3) step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    repeat (3) step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b1);
    repeat (3) step(4'b1001, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    cur = 4'b1111;
    repeat (3000) begin
      for (int j = 0; j < N; j++) if ($urandom_range(0, 3) == 0) cur[j] = ~cur[j];
      step(cur, $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one synchronous FIFO write port among N requesters.
- Grants one requester at a time for a burst of up to MAX_BURST words, then rotates priority.
- Drives the FIFO's wr_en/data_in directly and honours the FIFO full flag, so the FIFO can never be overwritten.
- Sits between producer blocks and the shared fifo instance; the read side is untouched.

Parameters:
- N, 4, number of requesters (2..16).
- DATA_WIDTH, 8, word width; matches the FIFO data width.
- MAX_BURST, 4, maximum consecutive words per grant (1..255).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N  req[i]=1: requester i has a valid word on its data slice.
- req_data  input  N*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  output  N  one-hot; gnt[i]=1 means requester i may write this cycle.
- fifo_full  input  1  FIFO full flag.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_data_in  output  DATA_WIDTH  FIFO write data.
- owner  output  $clog2(N)  index of the current or last burst owner.
- busy  output  1  1 while in BURST state.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, rr_ptr=0, owner=0, burst_cnt=0. Outputs: gnt=0, fifo_wr_en=0, busy=0, fifo_data_in=0. Reset mid-burst aborts the burst at the next edge; no partial state survives.
- FSM, two states: IDLE and BURST.
- IDLE:
  - On an edge with |req=1 and fifo_full=0, pick the first i scanning rr_ptr, rr_ptr+1, ... (mod N) with req[i]=1.
  - Set owner<=i, burst_cnt<=0, state<=BURST.
  - No write happens in the IDLE cycle, so each burst costs one arbitration cycle.
- BURST:
  - gnt[owner] = (req[owner] & ~fifo_full), combinational. All other gnt bits are 0.
  - Accept = gnt[owner] & req[owner].
  - fifo_wr_en = accept (combinational, same cycle). fifo_data_in = req_data slice of owner, muxed combinationally; it is 0 when not in BURST.
  - On an accept edge, burst_cnt increments.
  - If accept and burst_cnt==MAX_BURST-1: state<=IDLE, rr_ptr<=(owner+1) mod N.
  - If req[owner]=0: state<=IDLE, rr_ptr<=(owner+1) mod N, and no write that cycle.
  - If fifo_full=1 and req[owner]=1: hold state, owner and burst_cnt; gnt=0, fifo_wr_en=0; no timeout.
- busy = (state==BURST). owner is registered and holds its value in IDLE.
- Requester contract: keep data stable while req=1 and gnt=0. A word is consumed exactly on a cycle with req[i]&gnt[i].
- Full handling: fifo_wr_en is never asserted while fifo_full=1, so there is zero overflow by construction.
- Rotation: a requester that loses arbitration is served within N bursts. rr_ptr advances only at burst end, never on a stall.
- Simultaneous events:
  - rst has priority over everything.
  - req[owner] falling together with fifo_full rising ends the burst (IDLE).
  - N=1 degenerates to IDLE/BURST alternation with rr_ptr fixed at 0.

Test Plan (N=4, DATA_WIDTH=8, MAX_BURST=4):
1. rst=1 for 2 cycles with req=4'b1111, fifo_full=0 -> gnt=0, fifo_wr_en=0, busy=0, owner=0 throughout. Cycle after release: IDLE picks 0; next cycle gnt=4'b0001.
2. Only req[2]=1 continuously with data A0..A7 -> 1 idle cycle, 4 writes A0..A3 with gnt=4'b0100, 1 idle cycle, 4 writes A4..A7. owner=2, rr_ptr ends at 3.
3. req=4'b1111 continuously -> bursts owned 0,1,2,3,0 in that order, 4 words each, 1 idle cycle between bursts. Never more than one gnt bit high.
4. Owner 1 mid-burst: fifo_full=1 for 3 cycles after 2 words -> gnt=0 and fifo_wr_en=0 for those 3 cycles, owner stays 1, busy=1. Then 2 more words complete the burst (4 total), then rotate to 2.
5. req[1] drops after 2 accepted words (req=4'b0110 -> 4'b0100) -> busy falls at next edge, FIFO received exactly 2 words from 1, next burst owner=2.
6. rst pulse during the 3rd word of a burst by owner 3 -> next cycle busy=0, gnt=0, owner=0, rr_ptr=0. Next arbitration with req=4'b1001 picks 0.
